snax_csr_router: RTL and testbench
==================================

# snax_csr_router

Routes custom CSR accesses from the Snitch core to the SNAX accelerator CSR port. Decodes 12-bit CSR addresses against the SNAX window `snax_riscv_def::CSR_SNAX_BEGIN` (0x3C0) to `CSR_SNAX_END` (0x5FF), both inclusive. In-window requests are forwarded as window-relative offsets; out-of-window requests return an error. Sits between the core CSR/accelerator request port and the accelerator CSR manager, with one outstanding transaction.

## Interface
- `DataWidth`, 32, CSR data width.
- `OffsetWidth`, 10, accelerator offset width; must hold 0x23F.
- `TimeoutCycles`, 255, watchdog limit in cycles; used only with the macro.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `core_req_addr_i` in 12: CSR address.
- `core_req_data_i` in DataWidth: write data.
- `core_req_write_i` in 1: 1 = write, 0 = read.
- `core_req_valid_i` / `core_req_ready_o` in/out 1: core request handshake.
- `core_rsp_data_o` out DataWidth: read data.
- `core_rsp_err_o` out 1: error flag.
- `core_rsp_valid_o` / `core_rsp_ready_i` out/in 1: core response handshake.
- `acc_req_addr_o` out OffsetWidth: address minus 0x3C0.
- `acc_req_data_o` out DataWidth; `acc_req_write_o` out 1.
- `acc_req_valid_o` / `acc_req_ready_i` out/in 1: accelerator request handshake.
- `acc_rsp_data_i` in DataWidth; `acc_rsp_valid_i` / `acc_rsp_ready_o` in/out 1: accelerator read response.
- `busy_o` out 1: high whenever the FSM is not in IDLE.

## Operation
- Handshake rule: a transfer occurs when valid and ready are both high on a rising edge. Once valid is high, it and its payload are held until the transfer.
- FSM states: IDLE, FWD, WAIT, RESP.
- IDLE: `core_req_ready_o`=1. On accept, register address, data and write.
  - In window: next state FWD.
  - Out of window: next state RESP with err=1 and data=0.
- FWD: `acc_req_valid_o`=1, driving the registered fields; offset = addr − 0x3C0, truncated to OffsetWidth. On the handshake:
  - Write: next state RESP with err=0 and data=0.
  - Read: next state WAIT.
- WAIT: `acc_rsp_ready_o`=1. On `acc_rsp_valid_i`, register the data and go to RESP with err=0.
- RESP: `core_rsp_valid_o`=1 with the registered data and err. On `core_rsp_ready_i`, go to IDLE.
- Outside WAIT, `acc_rsp_ready_o`=0 (except for the drain case under Configuration). A stray accelerator response stalls and is not consumed.
- Boundaries:
  - 0x3BF and 0x600 are out of window.
  - 0x3C0 maps to offset 0; 0x5FF maps to offset 0x23F.
  - A new core request cannot be accepted in the same cycle the response handshake completes; ready returns the cycle after.

## Timing
- Reset values: all outputs 0, state IDLE, registers cleared. `core_req_ready_o` is 1 one cycle after reset deasserts.
- Reset asserted mid-transaction: the transaction is dropped and the next cycle is IDLE. No response is issued.
- Request accepted at edge N:
  - Out of window: `core_rsp_valid_o` high in cycle N+1.
  - In window: `acc_req_valid_o` high in cycle N+1.
  - Write with immediate `acc_req_ready_i`: response valid in N+2.
  - Read with immediate ready and immediate acc response: response valid in N+3.
- Throughput with zero backpressure: out of window, one request per 2 cycles; in-window write, one per 3; in-window read, one per 4.
- All outputs are registered or decoded from the state register only; there is no combinational input-to-output path.

## Configuration
- Macro: `SNAX_CSR_ROUTER_TIMEOUT_EN`.
- Defined:
  - A counter runs in WAIT. It is reset on entering WAIT and counts up each cycle without `acc_rsp_valid_i`.
  - When the count reaches TimeoutCycles, go to RESP with err=1 and data=0, and set a sticky `drain` bit.
  - While `drain`=1, `acc_rsp_ready_o`=1 in every state. The next accelerator response is consumed and discarded, then `drain` clears.
  - If WAIT is entered while `drain`=1, the first response is discarded, not returned.
  - Timeout never applies in FWD; request valid is never retracted.
- Undefined: no counter and no drain bit. WAIT holds indefinitely.

## Test plan
- Reset: hold `rst_i` 3 cycles mid-READ → all outputs 0; `core_req_ready_o`=1 the cycle after release; no response emitted.
- Write 0x3C0, data 0xDEADBEEF, acc ready immediate → `acc_req_addr_o`=0, write=1, data 0xDEADBEEF; core response err=0 in N+2.
- Read 0x5FF, acc returns 0x12345678 after 5 cycles, `core_rsp_ready_i` low 2 cycles → `acc_req_addr_o`=0x23F; core data 0x12345678, err=0; valid held stable through stall.
- Read 0x3BF, then write 0x600 → no acc activity; both responses err=1, data=0, valid in N+1.
- Backpressure: `acc_req_ready_i` low 4 cycles during a write → `acc_req_valid_o` and payload stable; `busy_o`=1 throughout.
- (Macro defined, TimeoutCycles=8) Read, acc silent 8 cycles, then responds 0xAA, then a second read returns 0xBB → first response err=1, 0xAA discarded, second response data 0xBB, err=0.

Source files
------------

// File: rtl/snax_csr_router.sv
// rtl/snax_csr_router.sv - Routes Snitch custom CSR accesses in 0x3C0..0x5FF to the SNAX accelerator CSR port
// Optional WAIT watchdog with response drain is enabled by defining SNAX_CSR_ROUTER_TIMEOUT_EN.
module snax_csr_router #(
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned OffsetWidth   = 10,
   parameter int unsigned TimeoutCycles = 255
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [11:0]            core_req_addr_i,
   input  logic [DataWidth-1:0]   core_req_data_i,
   input  logic                   core_req_write_i,
   input  logic                   core_req_valid_i,
   output logic                   core_req_ready_o,
   output logic [DataWidth-1:0]   core_rsp_data_o,
   output logic                   core_rsp_err_o,
   output logic                   core_rsp_valid_o,
   input  logic                   core_rsp_ready_i,
   output logic [OffsetWidth-1:0] acc_req_addr_o,
   output logic [DataWidth-1:0]   acc_req_data_o,
   output logic                   acc_req_write_o,
   output logic                   acc_req_valid_o,
   input  logic                   acc_req_ready_i,
   input  logic [DataWidth-1:0]   acc_rsp_data_i,
   input  logic                   acc_rsp_valid_i,
   output logic                   acc_rsp_ready_o,
   output logic                   busy_o
);

   localparam logic [11:0] CsrSnaxBegin = 12'h3C0;
   localparam logic [11:0] CsrSnaxEnd   = 12'h5FF;

   if (OffsetWidth < 10 || TimeoutCycles < 1) begin : g_bad_cfg
      $error("snax_csr_router: OffsetWidth must be >= 10 and TimeoutCycles >= 1");
   end

   typedef enum logic [1:0] {
      IDLE,
      FWD,
      WAIT,
      RESP
   } state_e;

   state_e                 state_q, state_d;
   logic                   active_q;
   logic [OffsetWidth-1:0] offset_q;
   logic [DataWidth-1:0]   req_data_q;
   logic                   write_q;
   logic [DataWidth-1:0]   rsp_data_q, rsp_data_d;
   logic                   rsp_err_q, rsp_err_d;
   logic                   rsp_load;
   logic                   req_fire;
   logic                   in_window;

   assign in_window = (core_req_addr_i >= CsrSnaxBegin) && (core_req_addr_i <= CsrSnaxEnd);

`ifdef SNAX_CSR_ROUTER_TIMEOUT_EN
   localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);

   logic [CntWidth-1:0] cnt_q;
   logic                drain_q;
   logic                timeout_hit;

   assign timeout_hit = (state_q == WAIT) && !acc_rsp_valid_i &&
                        (cnt_q == CntWidth'(TimeoutCycles - 1));

   // Counter is held at zero outside WAIT, so every entry into WAIT starts from 0.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         drain_q <= 1'b0;
      end else begin
         if (state_q != WAIT) begin
            cnt_q <= '0;
         end else if (!acc_rsp_valid_i) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (timeout_hit) begin
            drain_q <= 1'b1;
         end else if (drain_q && acc_rsp_valid_i) begin
            drain_q <= 1'b0;
         end
      end
   end
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      rsp_load         = 1'b0;
      rsp_data_d       = '0;
      rsp_err_d        = 1'b0;
      core_req_ready_o = 1'b0;
      core_rsp_valid_o = 1'b0;
      acc_req_valid_o  = 1'b0;
      acc_rsp_ready_o  = 1'b0;
      busy_o           = (state_q != IDLE);

      unique case (state_q)
         IDLE: begin
            // active_q keeps ready low through reset and its release cycle.
            core_req_ready_o = active_q;
            if (core_req_valid_i && active_q) begin
               if (in_window) begin
                  state_d = FWD;
               end else begin
                  state_d   = RESP;
                  rsp_load  = 1'b1;
                  rsp_err_d = 1'b1;
               end
            end
         end
         FWD: begin
            acc_req_valid_o = 1'b1;
            if (acc_req_ready_i) begin
               if (write_q) begin
                  state_d  = RESP;
                  rsp_load = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            acc_rsp_ready_o = 1'b1;
`ifdef SNAX_CSR_ROUTER_TIMEOUT_EN
            if (acc_rsp_valid_i && !drain_q) begin
               state_d    = RESP;
               rsp_load   = 1'b1;
               rsp_data_d = acc_rsp_data_i;
            end else if (timeout_hit) begin
               state_d   = RESP;
               rsp_load  = 1'b1;
               rsp_err_d = 1'b1;
            end
`else
            if (acc_rsp_valid_i) begin
               state_d    = RESP;
               rsp_load   = 1'b1;
               rsp_data_d = acc_rsp_data_i;
            end
`endif
         end
         RESP: begin
            core_rsp_valid_o = 1'b1;
            if (core_rsp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

`ifdef SNAX_CSR_ROUTER_TIMEOUT_EN
      // A late response from a timed-out read is swallowed in any state.
      if (drain_q) begin
         acc_rsp_ready_o = 1'b1;
      end
`endif
   end

   assign req_fire = core_req_ready_o && core_req_valid_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         active_q   <= 1'b0;
         offset_q   <= '0;
         req_data_q <= '0;
         write_q    <= 1'b0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         active_q <= 1'b1;
         if (req_fire) begin
            offset_q   <= OffsetWidth'(core_req_addr_i - CsrSnaxBegin);
            req_data_q <= core_req_data_i;
            write_q    <= core_req_write_i;
         end
         if (rsp_load) begin
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
         end
      end
   end

   assign acc_req_addr_o  = offset_q;
   assign acc_req_data_o  = req_data_q;
   assign acc_req_write_o = write_q;
   assign core_rsp_data_o = rsp_data_q;
   assign core_rsp_err_o  = rsp_err_q;

endmodule

// File: tb/tb_snax_csr_router.sv
// tb/tb_snax_csr_router.sv - Directed scoreboard bench for snax_csr_router
// Covers the watchdog/drain path when SNAX_CSR_ROUTER_TIMEOUT_EN is defined.
module tb_snax_csr_router;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] core_req_addr;
   logic [31:0] core_req_data;
   logic        core_req_write;
   logic        core_req_valid;
   logic        core_req_ready;
   logic [31:0] core_rsp_data;
   logic        core_rsp_err;
   logic        core_rsp_valid;
   logic        core_rsp_ready;
   logic [9:0]  acc_req_addr;
   logic [31:0] acc_req_data;
   logic        acc_req_write;
   logic        acc_req_valid;
   logic        acc_req_ready;
   logic [31:0] acc_rsp_data;
   logic        acc_rsp_valid;
   logic        acc_rsp_ready;
   logic        busy;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_rsp_t;

   exp_rsp_t exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   snax_csr_router #(
      .DataWidth     (32),
      .OffsetWidth   (10),
      .TimeoutCycles (8)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .core_req_addr_i  (core_req_addr),
      .core_req_data_i  (core_req_data),
      .core_req_write_i (core_req_write),
      .core_req_valid_i (core_req_valid),
      .core_req_ready_o (core_req_ready),
      .core_rsp_data_o  (core_rsp_data),
      .core_rsp_err_o   (core_rsp_err),
      .core_rsp_valid_o (core_rsp_valid),
      .core_rsp_ready_i (core_rsp_ready),
      .acc_req_addr_o   (acc_req_addr),
      .acc_req_data_o   (acc_req_data),
      .acc_req_write_o  (acc_req_write),
      .acc_req_valid_o  (acc_req_valid),
      .acc_req_ready_i  (acc_req_ready),
      .acc_rsp_data_i   (acc_rsp_data),
      .acc_rsp_valid_i  (acc_rsp_valid),
      .acc_rsp_ready_o  (acc_rsp_ready),
      .busy_o           (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "bench time limit");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic out_of_window(input logic [11:0] a);
      return (a < 12'h3C0) || (a > 12'h5FF);
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_req_ready"}, 32'(core_req_ready), 32'd0);
      check({tag, "_rsp_valid"}, 32'(core_rsp_valid), 32'd0);
      check({tag, "_rsp_data"},  core_rsp_data, 32'd0);
      check({tag, "_rsp_err"},   32'(core_rsp_err), 32'd0);
      check({tag, "_acc_valid"}, 32'(acc_req_valid), 32'd0);
      check({tag, "_acc_addr"},  32'(acc_req_addr), 32'd0);
      check({tag, "_acc_data"},  acc_req_data, 32'd0);
      check({tag, "_acc_write"}, 32'(acc_req_write), 32'd0);
      check({tag, "_rsp_ready"}, 32'(acc_rsp_ready), 32'd0);
      check({tag, "_busy"},      32'(busy), 32'd0);
   endtask

   // Drives one core request; on return the bench sits in the cycle after the accept edge.
   task automatic send_req(input logic [11:0] a, input logic [31:0] d, input logic w,
                           input logic push, input logic [31:0] rd_data);
      exp_rsp_t e;
      int cyc = 0;
      core_req_addr  = a;
      core_req_data  = d;
      core_req_write = w;
      core_req_valid = 1'b1;
      while (core_req_ready !== 1'b1 && cyc < 50) begin
         tick();
         cyc++;
      end
      check("req_ready_wait", 32'(core_req_ready), 32'd1);
      if (push) begin
         e.err  = out_of_window(a);
         e.data = (e.err || w) ? 32'd0 : rd_data;
         exp_q.push_back(e);
      end
      tick();
      core_req_valid = 1'b0;
   endtask

   task automatic get_rsp(input string tag, input int stall);
      exp_rsp_t e;
      int cyc = 0;
      while (core_rsp_valid !== 1'b1 && cyc < 50) begin
         tick();
         cyc++;
      end
      check({tag, "_rsp_valid"}, 32'(core_rsp_valid), 32'd1);
      check({tag, "_sb_empty"}, 32'(exp_q.size() == 0), 32'd0);
      if (core_rsp_valid !== 1'b1 || exp_q.size() == 0) return;
      e = exp_q.pop_front();
      core_rsp_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
         check({tag, "_stall_valid"}, 32'(core_rsp_valid), 32'd1);
         check({tag, "_stall_data"},  core_rsp_data, e.data);
         tick();
      end
      check({tag, "_data"}, core_rsp_data, e.data);
      check({tag, "_err"},  32'(core_rsp_err), 32'(e.err));
      check({tag, "_no_accept_in_resp"}, 32'(core_req_ready), 32'd0);
      core_rsp_ready = 1'b1;
      tick();
      core_rsp_ready = 1'b0;
      check({tag, "_ready_after_rsp"}, 32'(core_req_ready), 32'd1);
   endtask

   initial begin
      rst            = 1'b1;
      core_req_addr  = '0;
      core_req_data  = '0;
      core_req_write = 1'b0;
      core_req_valid = 1'b0;
      core_rsp_ready = 1'b0;
      acc_req_ready  = 1'b0;
      acc_rsp_data   = '0;
      acc_rsp_valid  = 1'b0;
      tick();
      tick();
      check_all_zero("por");
      rst = 1'b0;
      tick();
      check("por_ready", 32'(core_req_ready), 32'd1);

      // Reset in the middle of a read stalled in FWD.
      send_req(12'h400, 32'h0, 1'b0, 1'b0, 32'h0);
      check("mid_fwd_valid", 32'(acc_req_valid), 32'd1);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_all_zero("mid_rst");
      end
      rst = 1'b0;
      check("rst_release_ready", 32'(core_req_ready), 32'd0);
      tick();
      check("rst_after_ready", 32'(core_req_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         check("rst_no_rsp", 32'(core_rsp_valid), 32'd0);
         tick();
      end

      // Write to the first window address with an immediately ready accelerator.
      acc_req_ready = 1'b1;
      send_req(12'h3C0, 32'hDEADBEEF, 1'b1, 1'b1, 32'h0);
      check("wr_acc_valid", 32'(acc_req_valid), 32'd1);
      check("wr_acc_addr",  32'(acc_req_addr), 32'h0);
      check("wr_acc_write", 32'(acc_req_write), 32'd1);
      check("wr_acc_data",  acc_req_data, 32'hDEADBEEF);
      check("wr_busy",      32'(busy), 32'd1);
      tick();
      check("wr_rsp_n2", 32'(core_rsp_valid), 32'd1);
      check("wr_acc_done", 32'(acc_req_valid), 32'd0);
      get_rsp("wr3c0", 0);

      // Read the last window address; slow accelerator and stalled core.
      send_req(12'h5FF, 32'h0, 1'b0, 1'b1, 32'h12345678);
      check("rd_acc_addr",  32'(acc_req_addr), 32'h23F);
      check("rd_acc_write", 32'(acc_req_write), 32'd0);
      tick();
      for (int i = 0; i < 5; i++) begin
         check("rd_wait_rsp_ready", 32'(acc_rsp_ready), 32'd1);
         check("rd_wait_no_rsp", 32'(core_rsp_valid), 32'd0);
         tick();
      end
      acc_rsp_data  = 32'h12345678;
      acc_rsp_valid = 1'b1;
      tick();
      acc_rsp_valid = 1'b0;
      acc_rsp_data  = 32'h0;
      get_rsp("rd5ff", 2);

      // Just outside either end of the window.
      send_req(12'h3BF, 32'h0, 1'b0, 1'b1, 32'h0);
      check("oow_rd_rsp_n1", 32'(core_rsp_valid), 32'd1);
      check("oow_rd_no_acc", 32'(acc_req_valid), 32'd0);
      get_rsp("rd3bf", 0);
      send_req(12'h600, 32'hCAFEF00D, 1'b1, 1'b1, 32'h0);
      check("oow_wr_rsp_n1", 32'(core_rsp_valid), 32'd1);
      check("oow_wr_no_acc", 32'(acc_req_valid), 32'd0);
      get_rsp("wr600", 0);

      // Accelerator request backpressure.
      acc_req_ready = 1'b0;
      send_req(12'h4A5, 32'hA5A55A5A, 1'b1, 1'b1, 32'h0);
      for (int i = 0; i < 4; i++) begin
         check("bp_valid", 32'(acc_req_valid), 32'd1);
         check("bp_addr",  32'(acc_req_addr), 32'hE5);
         check("bp_data",  acc_req_data, 32'hA5A55A5A);
         check("bp_write", 32'(acc_req_write), 32'd1);
         check("bp_busy",  32'(busy), 32'd1);
         tick();
      end
      acc_req_ready = 1'b1;
      tick();
      get_rsp("bp_wr", 0);

      // A stray accelerator response while idle is not consumed.
      acc_rsp_valid = 1'b1;
      acc_rsp_data  = 32'h55;
      tick();
      check("stray_not_ready", 32'(acc_rsp_ready), 32'd0);
      check("stray_idle", 32'(busy), 32'd0);
      acc_rsp_valid = 1'b0;

`ifdef SNAX_CSR_ROUTER_TIMEOUT_EN
      send_req(12'h3C4, 32'h0, 1'b0, 1'b1, 32'h0);
      tick();
      for (int i = 0; i < 8; i++) begin
         check("to_wait_no_rsp", 32'(core_rsp_valid), 32'd0);
         tick();
      end
      get_rsp("timeout", 0);
      check("drain_ready_idle", 32'(acc_rsp_ready), 32'd1);
      acc_rsp_data  = 32'hAA;
      acc_rsp_valid = 1'b1;
      tick();
      acc_rsp_valid = 1'b0;
      acc_rsp_data  = 32'h0;
      check("drain_cleared", 32'(acc_rsp_ready), 32'd0);
      check("drain_no_rsp", 32'(core_rsp_valid), 32'd0);
      send_req(12'h3C8, 32'h0, 1'b0, 1'b1, 32'hBB);
      tick();
      acc_rsp_data  = 32'hBB;
      acc_rsp_valid = 1'b1;
      tick();
      acc_rsp_valid = 1'b0;
      get_rsp("after_drain", 0);
`endif

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
